// File: rtl/cb_config_loader.sv
// Bit-serial configuration loader for the connection-block tile: shifts a frame into a shadow
// register and commits it atomically to prog. Optional CRC-8 trailer check under CB_CFG_CRC_EN.
module cb_config_loader #(
  parameter int PROG_W = 69,
  parameter int CRC_W  = 8
) (
  input  logic              clb_clk,
  input  logic              clb_rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic [PROG_W-1:0] prog,
  output logic              prog_valid,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

`ifdef CB_CFG_CRC_EN
  localparam int CRC_EN = 1;
`else
  localparam int CRC_EN = 0;
`endif
  localparam int         FRAME_W  = PROG_W + CRC_EN * CRC_W;
  localparam logic [6:0] LAST_CNT = 7'(FRAME_W - 1);
  localparam logic [6:0] DATA_CNT = 7'(PROG_W);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t            state, state_nxt;
  logic [6:0]        cnt;
  logic [PROG_W-1:0] shadow;
  logic              clear, accept, last_bit, commit;

  // A start pulse wins over a bit offered in the same cycle.
  assign clear    = cfg_start && (state != CHECK);
  assign accept   = cfg_valid && cfg_ready && !cfg_start;
  assign last_bit = accept && (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CB_CFG_CRC_EN
  localparam logic [CRC_W-1:0] POLY = CRC_W'(8'h07);

  logic [CRC_W-1:0] crc, rx_crc;
  logic             fb;

  assign fb     = crc[CRC_W-1] ^ cfg_bit;
  assign commit = (state == CHECK) && (crc == rx_crc);

  always_ff @(posedge clb_clk or negedge clb_rst_n) begin
    if (!clb_rst_n) begin
      crc     <= '0;
      rx_crc  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == CHECK) && (crc != rx_crc);
      if (clear) begin
        crc    <= '0;
        rx_crc <= '0;
      end else if (accept) begin
        if (cnt < DATA_CNT) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        else                rx_crc <= {rx_crc[CRC_W-2:0], cfg_bit};
      end
    end
  end
`else
  assign commit  = (state == CHECK);
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clb_clk or negedge clb_rst_n) begin
    if (!clb_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      cfg_ready  <= 1'b0;
      cfg_busy   <= 1'b0;
      prog       <= '0;
      prog_valid <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == SHIFT);
      cfg_busy  <= (state_nxt != IDLE);
      cfg_done  <= commit;
      if (clear) begin
        cnt    <= '0;
        shadow <= '0;
      end else if (accept) begin
        cnt <= cnt + 7'd1;
        // First data bit ends up in the MSB of prog.
        if (cnt < DATA_CNT) shadow <= {shadow[PROG_W-2:0], cfg_bit};
      end
      if (commit) begin
        prog       <= shadow;
        prog_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader: table of frames plus restart and mid-frame reset sequences.
// Works with or without CB_CFG_CRC_EN defined.
module tb_cb_config_loader;
  localparam int PROG_W = 69;
`ifdef CB_CFG_CRC_EN
  localparam int FRAME_W = PROG_W + 8;
`else
  localparam int FRAME_W = PROG_W;
`endif
  localparam int LAT = FRAME_W + 2;

  logic              clb_clk = 1'b0;
  logic              clb_rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_bit = 1'b0;
  logic              cfg_ready;
  logic [PROG_W-1:0] prog;
  logic              prog_valid;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;

  int tests = 0;
  int fails = 0;

  cb_config_loader dut (
    .clb_clk(clb_clk), .clb_rst_n(clb_rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .prog(prog), .prog_valid(prog_valid),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clb_clk = ~clb_clk;

  typedef struct {
    logic [68:0] data;
    bit          corrupt;
    bit          toggle;
    int          exp_lat;   // -1: latency not checked
    int          exp_done;
    int          exp_err;
    logic [68:0] exp_prog;
  } vec_t;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [68:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 68; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Pulses start (with a junk bit offered that must be discarded), then streams the frame.
  task automatic run_frame(input logic [68:0] d, input bit corrupt, input bit toggle,
                           output int lat, output int ndone, output int nerr,
                           output int nacc, output int viol);
    logic [FRAME_W-1:0] fr;
    int idx;
`ifdef CB_CFG_CRC_EN
    fr = {d, crc8(d)};
    fr[0] = fr[0] ^ corrupt;
`else
    fr = d;
`endif
    idx = 0; lat = -1; ndone = 0; nerr = 0; nacc = -1; viol = 0;
    @(negedge clb_clk);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clb_clk);
      cfg_start = 1'b0;
      if (cfg_ready && !cfg_busy) viol++;
      if (cfg_done) begin
        ndone++;
        if (lat < 0) begin lat = k; nacc = idx; end
      end
      if (cfg_err) begin
        nerr++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 3) break;
      if (idx < FRAME_W) begin
        cfg_valid = toggle ? ((k % 2) == 1) : 1'b1;
        cfg_bit   = fr[FRAME_W-1-idx];
        if (cfg_valid && cfg_ready) idx++;
      end else begin
        cfg_valid = 1'b0;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_junk(input int n);
    @(negedge clb_clk);
    cfg_start = 1'b1; cfg_valid = 1'b0;
    @(negedge clb_clk);
    cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom_range(0, 1));
      @(negedge clb_clk);
    end
    cfg_valid = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int lat, nd, ne, na, vi;

    v = '{69'h1_0000_0000_0000_0001, 1'b0, 1'b0, LAT, 1, 0, 69'h1_0000_0000_0000_0001};
    vecs.push_back(v);
`ifdef CB_CFG_CRC_EN
    v = '{69'h1_0000_0000_0000_0001 ^ 69'h3, 1'b1, 1'b0, LAT, 0, 1, 69'h1_0000_0000_0000_0001};
    vecs.push_back(v);
`endif
    v = '{69'h0_AAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, -1, 1, 0, 69'h0_AAAA_AAAA_AAAA_AAAA};
    vecs.push_back(v);
    v = '{69'h1F_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, LAT, 1, 0, 69'h1F_FFFF_FFFF_FFFF_FFFF};
    vecs.push_back(v);

    repeat (3) @(negedge clb_clk);
    check("rst_prog", prog, 69'h0);
    check("rst_prog_valid", 69'(prog_valid), 69'h0);
    check("rst_ready", 69'(cfg_ready), 69'h0);
    check("rst_busy", 69'(cfg_busy), 69'h0);
    check("rst_done", 69'(cfg_done), 69'h0);
    check("rst_err", 69'(cfg_err), 69'h0);
    clb_rst_n = 1'b1;
    repeat (2) @(negedge clb_clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].corrupt, vecs[i].toggle, lat, nd, ne, na, vi);
      check($sformatf("v%0d_done_cnt", i), 69'(nd), 69'(vecs[i].exp_done));
      check($sformatf("v%0d_err_cnt", i), 69'(ne), 69'(vecs[i].exp_err));
      check($sformatf("v%0d_prog", i), prog, vecs[i].exp_prog);
      check($sformatf("v%0d_prog_valid", i), 69'(prog_valid), 69'h1);
      check($sformatf("v%0d_ready_idle", i), 69'(vi), 69'h0);
      if (vecs[i].exp_lat >= 0)
        check($sformatf("v%0d_latency", i), 69'(lat), 69'(vecs[i].exp_lat));
      if (vecs[i].exp_done > 0)
        check($sformatf("v%0d_bits_accepted", i), 69'(na), 69'(FRAME_W));
    end

    // Restart after 40 junk bits: only the second word commits.
    send_junk(40);
    check("restart_busy_mid", 69'(cfg_busy), 69'h1);
    check("restart_prog_held", prog, 69'h1F_FFFF_FFFF_FFFF_FFFF);
    run_frame(69'h1F_FFFF_FFFF_0000_0000, 1'b0, 1'b0, lat, nd, ne, na, vi);
    check("restart_done_cnt", 69'(nd), 69'h1);
    check("restart_err_cnt", 69'(ne), 69'h0);
    check("restart_prog", prog, 69'h1F_FFFF_FFFF_0000_0000);
    check("restart_latency", 69'(lat), 69'(LAT));

    // Asynchronous reset 30 bits into a frame clears the committed word too.
    send_junk(30);
    clb_rst_n = 1'b0;
    #1;
    check("mrst_prog", prog, 69'h0);
    check("mrst_prog_valid", 69'(prog_valid), 69'h0);
    check("mrst_busy", 69'(cfg_busy), 69'h0);
    check("mrst_ready", 69'(cfg_ready), 69'h0);
    @(negedge clb_clk);
    clb_rst_n = 1'b1;
    run_frame(69'h0_1234_5678_9ABC_DEF0, 1'b0, 1'b0, lat, nd, ne, na, vi);
    check("post_rst_done_cnt", 69'(nd), 69'h1);
    check("post_rst_prog", prog, 69'h0_1234_5678_9ABC_DEF0);
    check("post_rst_prog_valid", 69'(prog_valid), 69'h1);
    check("post_rst_latency", 69'(lat), 69'(LAT));
    check("post_rst_idle_busy", 69'(cfg_busy), 69'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
